// File: rtl/quad_sd_channel.sv
// Quadrature sigma-delta channel: tick divider, Gray phase, +/-1 window integrators, result handshake.
// Optional macro CCLK_SWAP_EN adds a threshold-cap swap clock toggling on every tick.
module quad_sd_channel #(
    parameter int DIV_W = 10,
    parameter int WIN_W = 8,
    parameter int ACC_W = 8
) (
    input  logic                    clk_master,
    input  logic                    rstb,
    input  logic                    ud_en,
    input  logic [DIV_W-1:0]        div_ratio,
    input  logic [WIN_W-1:0]        win_len,
    input  logic                    comp_high_I,
    input  logic                    comp_high_Q,
    input  logic                    out_ready,
    output logic                    sin_out,
    output logic                    cos_out,
    output logic                    cclk,
    output logic                    fb1_I,
    output logic                    fb1_Q,
    output logic signed [ACC_W-1:0] read_out_I,
    output logic signed [ACC_W-1:0] read_out_Q,
    output logic                    out_valid,
    output logic                    overrun
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

    function automatic logic signed [ACC_W-1:0] sat_step(
        input logic signed [ACC_W-1:0] acc,
        input logic                    up
    );
        if (up)
            return (acc == ACC_MAX) ? ACC_MAX : acc + ACC_ONE;
        else
            return (acc == ACC_MIN) ? ACC_MIN : acc - ACC_ONE;
    endfunction

    logic                    r_comp_i_p0, r_comp_i_p1;
    logic                    r_comp_q_p0, r_comp_q_p1;
    logic [DIV_W-1:0]        r_ph_cnt;
    logic [1:0]              r_q;
    logic [WIN_W-1:0]        r_win_cnt;
    logic signed [ACC_W-1:0] r_acc_i, r_acc_q;
    logic                    r_fb1_i, r_fb1_q;
    logic signed [ACC_W-1:0] r_read_i, r_read_q;
    logic                    r_out_valid, r_overrun;

    logic                    w_tick;
    logic                    w_win_end;
    logic signed [ACC_W-1:0] w_acc_i_nxt, w_acc_q_nxt;

    assign w_tick      = ud_en && (r_ph_cnt >= div_ratio);
    assign w_win_end   = w_tick && (r_win_cnt >= win_len);
    assign w_acc_i_nxt = sat_step(r_acc_i, r_comp_i_p1);
    assign w_acc_q_nxt = sat_step(r_acc_q, r_comp_q_p1);

    // Stage p0/p1: two-flop synchronizers on the asynchronous comparator decisions
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            r_comp_i_p0 <= 1'b0;
            r_comp_i_p1 <= 1'b0;
            r_comp_q_p0 <= 1'b0;
            r_comp_q_p1 <= 1'b0;
        end else begin
            r_comp_i_p0 <= comp_high_I;
            r_comp_i_p1 <= r_comp_i_p0;
            r_comp_q_p0 <= comp_high_Q;
            r_comp_q_p1 <= r_comp_q_p0;
        end
    end

    // Divider, Gray phase, feedback and window integration, all advanced by the tick
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            r_ph_cnt  <= '0;
            r_q       <= 2'b00;
            r_win_cnt <= '0;
            r_acc_i   <= '0;
            r_acc_q   <= '0;
            r_fb1_i   <= 1'b0;
            r_fb1_q   <= 1'b0;
        end else if (ud_en) begin
            if (w_tick) begin
                r_ph_cnt <= '0;
                r_q      <= {r_q[0], ~r_q[1]};
                r_fb1_i  <= r_comp_i_p1;
                r_fb1_q  <= r_comp_q_p1;
                if (w_win_end) begin
                    r_win_cnt <= '0;
                    r_acc_i   <= '0;
                    r_acc_q   <= '0;
                end else begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    r_acc_i   <= w_acc_i_nxt;
                    r_acc_q   <= w_acc_q_nxt;
                end
            end else begin
                r_ph_cnt <= r_ph_cnt + 1'b1;
            end
        end
    end

    // Result register and valid/ready handshake; runs even while the channel is disabled
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            r_read_i    <= '0;
            r_read_q    <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_win_end) begin
            r_read_i    <= w_acc_i_nxt;
            r_read_q    <= w_acc_q_nxt;
            r_out_valid <= 1'b1;
            if (r_out_valid && !out_ready)
                r_overrun <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef CCLK_SWAP_EN
    logic r_cclk;

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb)
            r_cclk <= 1'b0;
        else if (w_tick)
            r_cclk <= ~r_cclk;
    end

    assign cclk = r_cclk;
`else
    assign cclk = 1'b0;
`endif

    assign cos_out    = r_q[0];
    assign sin_out    = r_q[1];
    assign fb1_I      = r_fb1_i;
    assign fb1_Q      = r_fb1_q;
    assign read_out_I = r_read_i;
    assign read_out_Q = r_read_q;
    assign out_valid  = r_out_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_quad_sd_channel.sv
// Directed self-checking bench for quad_sd_channel (default parameters).
// Edge numbers in comments count rising edges since the most recent reset release.
module tb_quad_sd_channel;

    localparam int DIV_W = 10;
    localparam int WIN_W = 8;
    localparam int ACC_W = 8;
`ifdef CCLK_SWAP_EN
    localparam logic CCLK_ON = 1'b1;
`else
    localparam logic CCLK_ON = 1'b0;
`endif

    logic                    clk_master = 1'b0;
    logic                    rstb;
    logic                    ud_en;
    logic [DIV_W-1:0]        div_ratio;
    logic [WIN_W-1:0]        win_len;
    logic                    comp_high_I, comp_high_Q;
    logic                    out_ready;
    logic                    sin_out, cos_out, cclk;
    logic                    fb1_I, fb1_Q;
    logic signed [ACC_W-1:0] read_out_I, read_out_Q;
    logic                    out_valid, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    quad_sd_channel #(.DIV_W(DIV_W), .WIN_W(WIN_W), .ACC_W(ACC_W)) dut (
        .clk_master (clk_master),
        .rstb       (rstb),
        .ud_en      (ud_en),
        .div_ratio  (div_ratio),
        .win_len    (win_len),
        .comp_high_I(comp_high_I),
        .comp_high_Q(comp_high_Q),
        .out_ready  (out_ready),
        .sin_out    (sin_out),
        .cos_out    (cos_out),
        .cclk       (cclk),
        .fb1_I      (fb1_I),
        .fb1_Q      (fb1_Q),
        .read_out_I (read_out_I),
        .read_out_Q (read_out_Q),
        .out_valid  (out_valid),
        .overrun    (overrun)
    );

    always #5 clk_master = ~clk_master;

    task automatic step(input int n);
        repeat (n) @(posedge clk_master);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rstb        = 1'b0;
        ud_en       = 1'b1;
        div_ratio   = 10'd3;
        win_len     = 8'd9;
        comp_high_I = 1'b1;
        comp_high_Q = 1'b0;
        out_ready   = 1'b1;
        step(2);
        chk("rst_sin", sin_out, 0);
        chk("rst_cos", cos_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rdI", read_out_I, 0);
        chk("rst_fb1I", fb1_I, 0);
        chk("rst_cclk", cclk, 0);
        rstb = 1'b1;

        // div_ratio=3: ticks at E4, E8, ...; cos leads sin by 4 cycles
        step(3);
        chk("no_early_tick", cos_out, 0);
        step(1);
        chk("t1_cos", cos_out, 1);
        chk("t1_sin", sin_out, 0);
        chk("t1_fb1I", fb1_I, 1);
        chk("t1_fb1Q", fb1_Q, 0);
        chk("t1_cclk", cclk, CCLK_ON);
        step(4);
        chk("t2_sin", sin_out, 1);
        chk("t2_cos", cos_out, 1);
        chk("t2_cclk", cclk, 0);
        step(4);
        chk("t3_cos", cos_out, 0);
        chk("t3_sin", sin_out, 1);
        step(4);
        chk("t4_sin", sin_out, 0);
        chk("t4_cos", cos_out, 0);

        // win_len=9: ten ticks per window, first window ends at E40
        step(23);
        chk("w1_pre_valid", out_valid, 0);
        step(1);
        chk("w1_valid", out_valid, 1);
        chk("w1_rdI", read_out_I, 10);
        chk("w1_rdQ", read_out_Q, -10);
        step(1);
        chk("w1_consumed", out_valid, 0);
        out_ready   = 1'b0;
        comp_high_I = 1'b0;
        comp_high_Q = 1'b1;

        // Two window ends without consumption
        step(39);
        chk("w2_valid", out_valid, 1);
        chk("w2_rdI", read_out_I, -10);
        chk("w2_rdQ", read_out_Q, 10);
        chk("w2_overrun", overrun, 0);
        step(1);
        chk("w2_hold_valid", out_valid, 1);
        comp_high_I = 1'b1;
        step(38);
        chk("w3_pre_rdI", read_out_I, -10);
        step(1);
        chk("w3_rdI", read_out_I, 10);
        chk("w3_rdQ", read_out_Q, 10);
        chk("w3_valid", out_valid, 1);
        chk("w3_overrun", overrun, 1);
        out_ready = 1'b1;
        step(1);
        chk("w3_consumed", out_valid, 0);
        chk("w3_overrun_sticky", overrun, 1);
        comp_high_Q = 1'b0;

        // Freeze E131..E150; last tick before freeze at E128 leaves q=00
        step(9);
        ud_en = 1'b0;
        step(10);
        chk("frz_cos", cos_out, 0);
        chk("frz_sin", sin_out, 0);
        chk("frz_valid", out_valid, 0);
        step(10);
        ud_en = 1'b1;
        step(1);
        chk("resume_no_tick", cos_out, 0);
        step(1);
        chk("resume_tick", cos_out, 1);
        step(27);
        chk("w4_pre_valid", out_valid, 0);
        step(1);
        chk("w4_valid", out_valid, 1);
        chk("w4_rdI", read_out_I, 10);
        chk("w4_rdQ", read_out_Q, -10);
        chk("w4_overrun", overrun, 1);

        // Mid-window reset at E190: everything clears asynchronously
        step(10);
        rstb = 1'b0;
        #1;
        chk("mrst_sin", sin_out, 0);
        chk("mrst_cos", cos_out, 0);
        chk("mrst_fb1I", fb1_I, 0);
        chk("mrst_rdI", read_out_I, 0);
        chk("mrst_overrun", overrun, 0);
        chk("mrst_cclk", cclk, 0);
        @(posedge clk_master);
        #1;
        rstb = 1'b1;
        step(4);
        chk("r_t1_cos", cos_out, 1);
        chk("r_t1_cclk", cclk, CCLK_ON);
        step(4);
        chk("r_t2_sin", sin_out, 1);
        chk("r_t2_cclk", cclk, 0);
        step(31);
        chk("r_w_pre_valid", out_valid, 0);
        step(1);
        chk("r_w_valid", out_valid, 1);
        chk("r_w_rdI", read_out_I, 10);
        chk("r_w_rdQ", read_out_Q, -10);

        // q=10 after tick 11 at E44; lowering div_ratio gives a tick on the next edge
        step(6);
        chk("lo_pre_sin", sin_out, 1);
        chk("lo_pre_cos", cos_out, 0);
        div_ratio = 10'd0;
        step(1);
        chk("lo_t12_sin", sin_out, 0);
        chk("lo_t12_cos", cos_out, 0);
        step(1);
        chk("lo_t13_cos", cos_out, 1);
        step(1);
        chk("lo_t14_sin", sin_out, 1);

        // Saturation: 256 ticks of +1 / -1 clamp at +127 / -128
        rstb      = 1'b0;
        ud_en     = 1'b0;
        win_len   = 8'd255;
        @(posedge clk_master);
        #1;
        rstb = 1'b1;
        step(3);
        ud_en = 1'b1;
        step(255);
        chk("sat_pre_valid", out_valid, 0);
        step(1);
        chk("sat_valid", out_valid, 1);
        chk("sat_rdI", read_out_I, 127);
        chk("sat_rdQ", read_out_Q, -128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
